eq_band_mixer: RTL
==================

Name: eq_band_mixer

Overview:
- Downstream of the FIR filter bank. Consumes the per-band 48-bit FIR accumulator outputs for left and right, one strobe per stereo sample.
- Scales each band by a host-programmable gain and sums the bands into one equalised 24-bit stereo sample.
- Time-multiplexes one multiply-accumulate per channel across bands. Output feeds the audio output/DAC path.

Parameters:
- NUM_BANDS, 4, number of filter bands summed (1..16)
- GAIN_W, 16, gain word width; signed Q2.14, unity = 16'h4000

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- audio_en  in  1  low = abort/hold in IDLE
- gain_wr_en  in  1  gain write strobe
- gain_select  in  4  band index for the gain write
- gain_wr_lsb_data  in  8  gain[7:0]
- gain_wr_msb_data  in  8  gain[15:8]
- band_valid  in  1  one-cycle strobe; all band inputs valid this cycle
- l_band_in[NUM_BANDS]  in  48 each  left FIR band outputs, signed
- r_band_in[NUM_BANDS]  in  48 each  right FIR band outputs, signed
- l_data_out  out  24  left mixed sample, signed
- r_data_out  out  24  right mixed sample, signed
- data_valid_out  out  1  one-cycle strobe with the new output sample
- clip_l, clip_r  out  1  high with data_valid_out when that channel saturated
- busy  out  1  high while not in IDLE
- missed_stb  out  1  sticky; band_valid arrived while busy

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; all gain registers 16'h4000.
- Gain write: on gain_wr_en with gain_select < NUM_BANDS, gain[gain_select] <= {msb,lsb} next cycle. gain_select >= NUM_BANDS is ignored. Writes are accepted in any state, including while audio_en is low.
- State machine: IDLE -> MAC -> ROUND -> IDLE.
  - IDLE: band_valid && audio_en latches all 2*NUM_BANDS inputs and a shadow copy of all gains, clears both accumulators, sets band_idx=0, goes to MAC.
  - MAC, one band per cycle:
    - bs = sat24((band_in[band_idx] + 2^14) >>> 15), i.e. round-half-up then saturate to signed 24 bits.
    - acc += bs * shadow_gain[band_idx]; the product is 40-bit signed, acc is 44-bit signed.
    - band_idx increments; after band NUM_BANDS-1, go to ROUND.
    - Both channels are processed in parallel using the same gain.
  - ROUND:
    - l/r_data_out <= sat24((acc + 2^13) >>> 14).
    - clip_x <= 1 if either saturation stage clipped on that channel during this sample.
    - data_valid_out <= 1 for exactly one cycle.
    - Go to IDLE.
- Latency: band_valid at cycle 0 -> data_valid_out high at cycle NUM_BANDS+2 (6 at default). Minimum band_valid spacing is NUM_BANDS+2 cycles.
- Output hold: l/r_data_out hold their value until the next ROUND. clip_l/clip_r are 0 whenever data_valid_out is 0.
- band_valid while busy: ignored, and missed_stb is set. missed_stb is cleared only by reset. A band_valid in the same cycle as ROUND is also ignored.
- Gain coherence: gain writes during MAC/ROUND do not affect the sample in flight (shadow copy). They apply from the next capture.
- audio_en low in any state: next cycle is IDLE, data_valid_out=0, clip=0. l/r_data_out and missed_stb hold their values. Any sample in flight is discarded.
- Reset mid-MAC: all state returns to reset values next cycle, and no data_valid_out follows.
- Arithmetic: all operations are signed two's complement. Saturation limits are +8388607 and -8388608. The 44-bit accumulator cannot overflow for NUM_BANDS <= 16.

Test Plan:
- Unity gains; l_band_in[0]=1000<<15, other bands 0; r_band_in[2]=-500<<15 -> at cycle 6: l_data_out=1000, r_data_out=-500, data_valid_out pulses once, clip=0.
- Write gain[1]=16'h2000 (0.5) and gain[3]=16'hC000 (-1.0); l_band_in[1]=2000<<15, l_band_in[3]=300<<15 -> l_data_out=700.
- Rounding: l_band_in[0]=48'sd16384 (0.5 LSB) -> 1; l_band_in[0]=48'sd16383 -> 0; l_band_in[0]=-48'sd16384 -> 0.
- Saturation: all four l bands = 8388607<<15 at unity -> l_data_out=24'h7FFFFF, clip_l=1. All four = -8388608<<15 -> 24'h800000, clip_l=1. Right channel at 0 -> clip_r=0.
- band_valid at cycles 0 and 3 -> single output at cycle 6 from the cycle-0 data, missed_stb=1. Write gain_select=4'd9 -> all gains unchanged.
- Gain write to band 0 at cycle 2 of a sample -> that output uses the old gain, next sample uses the new one. Reset at cycle 3 -> no data_valid_out, outputs 0, gains 16'h4000. audio_en low at cycle 2 -> no data_valid_out, previous outputs held.

Source files
------------

// File: rtl/eq_band_mixer_if.sv
// Port bundle for eq_band_mixer: gain programming, band inputs from the FIR bank
// and the mixed stereo output toward the DAC path.
interface eq_band_mixer_if #(
  parameter int NUM_BANDS = 4
);
  logic                     audio_en;
  logic                     gain_wr_en;
  logic [3:0]               gain_select;
  logic [7:0]               gain_wr_lsb_data;
  logic [7:0]               gain_wr_msb_data;
  logic                     band_valid;
  logic signed [47:0]       l_band_in [NUM_BANDS];
  logic signed [47:0]       r_band_in [NUM_BANDS];
  logic signed [23:0]       l_data_out;
  logic signed [23:0]       r_data_out;
  logic                     data_valid_out;
  logic                     clip_l;
  logic                     clip_r;
  logic                     busy;
  logic                     missed_stb;

  modport master (
    output audio_en, gain_wr_en, gain_select, gain_wr_lsb_data, gain_wr_msb_data,
    output band_valid, l_band_in, r_band_in,
    input  l_data_out, r_data_out, data_valid_out, clip_l, clip_r, busy, missed_stb
  );

  modport slave (
    input  audio_en, gain_wr_en, gain_select, gain_wr_lsb_data, gain_wr_msb_data,
    input  band_valid, l_band_in, r_band_in,
    output l_data_out, r_data_out, data_valid_out, clip_l, clip_r, busy, missed_stb
  );
endinterface

// File: rtl/eq_band_mixer.sv
// Per-band gain and summing mixer: one time-shared MAC per channel walks the
// captured FIR band outputs, then rounds and saturates to a 24-bit stereo sample.
module eq_band_mixer #(
  parameter int NUM_BANDS = 4,
  parameter int GAIN_W    = 16
) (
  input  logic           clk,
  input  logic           reset,
  eq_band_mixer_if.slave bus
);

  localparam int OUT_W  = 24;
  localparam int PROD_W = OUT_W + GAIN_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(1 << (GAIN_W - 2));
  localparam logic signed [48:0]       POS_LIM = 49'sd8388607;
  localparam logic signed [48:0]       NEG_LIM = -49'sd8388608;

  typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

  state_t state, state_nxt;

  logic capture, mac_en, round_en, last_band;
  logic [IDX_W-1:0] band_idx;

  logic signed [GAIN_W-1:0] gain      [NUM_BANDS];
  logic signed [GAIN_W-1:0] gain_p0   [NUM_BANDS];
  logic signed [47:0]       l_band_p0 [NUM_BANDS];
  logic signed [47:0]       r_band_p0 [NUM_BANDS];

  logic signed [ACC_W-1:0]  acc_l_p1, acc_r_p1;
  logic                     clipf_l_p1, clipf_r_p1;

  logic signed [48:0]       bw_l, bw_r, aw_l, aw_r;
  logic signed [OUT_W-1:0]  bs_l, bs_r;
  logic signed [PROD_W-1:0] prod_l, prod_r;

  // Band inputs carry 15 fractional bits; round half-up into the 24-bit domain.
  function automatic logic signed [48:0] round_band(input logic signed [47:0] b);
    logic signed [48:0] w;
    w = 49'(b);
    return (w + 49'sd16384) >>> 15;
  endfunction

  // Accumulator carries the Q2.14 gain fraction; round half-up back to samples.
  function automatic logic signed [48:0] round_acc(input logic signed [ACC_W-1:0] a);
    logic signed [48:0] w;
    w = 49'(a);
    return (w + 49'sd8192) >>> 14;
  endfunction

  function automatic logic clips24(input logic signed [48:0] v);
    return (v > POS_LIM) || (v < NEG_LIM);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat24(input logic signed [48:0] v);
    if (v > POS_LIM)      return 24'sh7FFFFF;
    else if (v < NEG_LIM) return -24'sd8388608;
    else                  return v[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.audio_en && bus.band_valid) state_nxt = MAC;
      MAC:     if (!bus.audio_en) state_nxt = IDLE;
               else if (last_band) state_nxt = ROUND;
      ROUND:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture  = (state == IDLE)  && bus.audio_en && bus.band_valid;
    mac_en   = (state == MAC)   && bus.audio_en;
    round_en = (state == ROUND) && bus.audio_en;
    bus.busy = (state != IDLE);
  end

  assign last_band = (band_idx == IDX_W'(NUM_BANDS - 1));

  always_comb begin
    bw_l   = round_band(l_band_p0[band_idx]);
    bw_r   = round_band(r_band_p0[band_idx]);
    bs_l   = sat24(bw_l);
    bs_r   = sat24(bw_r);
    prod_l = PROD_W'(bs_l) * PROD_W'(gain_p0[band_idx]);
    prod_r = PROD_W'(bs_r) * PROD_W'(gain_p0[band_idx]);
    aw_l   = round_acc(acc_l_p1);
    aw_r   = round_acc(acc_r_p1);
  end

  // p0: capture bands and shadow gains; p1: accumulate one band per cycle
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        l_band_p0[i] <= bus.l_band_in[i];
        r_band_p0[i] <= bus.r_band_in[i];
        gain_p0[i]   <= gain[i];
      end
      acc_l_p1   <= '0;
      acc_r_p1   <= '0;
      clipf_l_p1 <= 1'b0;
      clipf_r_p1 <= 1'b0;
    end else if (mac_en) begin
      acc_l_p1   <= acc_l_p1 + ACC_W'(prod_l);
      acc_r_p1   <= acc_r_p1 + ACC_W'(prod_r);
      clipf_l_p1 <= clipf_l_p1 | clips24(bw_l);
      clipf_r_p1 <= clipf_r_p1 | clips24(bw_r);
    end
  end

  // p2: round/saturate the accumulators into the held output sample
  always_ff @(posedge clk) begin
    if (reset) begin
      band_idx           <= '0;
      bus.l_data_out     <= '0;
      bus.r_data_out     <= '0;
      bus.data_valid_out <= 1'b0;
      bus.clip_l         <= 1'b0;
      bus.clip_r         <= 1'b0;
      bus.missed_stb     <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) gain[i] <= UNITY;
    end else begin
      bus.data_valid_out <= 1'b0;
      bus.clip_l         <= 1'b0;
      bus.clip_r         <= 1'b0;
      if (capture)     band_idx <= '0;
      else if (mac_en) band_idx <= band_idx + 1'b1;
      if (round_en) begin
        bus.l_data_out     <= sat24(aw_l);
        bus.r_data_out     <= sat24(aw_r);
        bus.data_valid_out <= 1'b1;
        bus.clip_l         <= clipf_l_p1 | clips24(aw_l);
        bus.clip_r         <= clipf_r_p1 | clips24(aw_r);
      end
      if (bus.band_valid && bus.audio_en && (state != IDLE)) bus.missed_stb <= 1'b1;
      // Live gains are independent of the sample in flight, which uses gain_p0.
      if (bus.gain_wr_en && (5'(bus.gain_select) < 5'(NUM_BANDS)))
        gain[bus.gain_select[IDX_W-1:0]] <=
          GAIN_W'({bus.gain_wr_msb_data, bus.gain_wr_lsb_data});
    end
  end

endmodule
